// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
`timescale 1ns/1ps
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN_DEFAULT = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // One-hot mask for a register number; x0 maps to an empty mask so it can
    // never be marked busy or cleared.
    function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        m[r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between write-back sources, decode, and the register-file port.
`timescale 1ns/1ps
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = XLEN_DEFAULT
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_rd;
    logic [XLEN*NUM_REQ-1:0]       req_data;

    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic                  stall;
    logic [NUM_REGS-1:0]   busy_vec;

    // Execute/memory units and decode side.
    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  req_ready, RegWrite, wb_rd, wb_data, stall, busy_vec
    );

    // Write-back controller side.
    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd, chk_rs1, chk_rs2,
        output req_ready, RegWrite, wb_rd, wb_data, stall, busy_vec
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward, wrapping modulo NUM_REQ.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // First valid requester at or after the pointer wins a one-hot grant.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin onto the single register-file write port,
// plus a busy scoreboard that stalls decode on RAW/WAW hazards.
`timescale 1ns/1ps
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = XLEN_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  regWrite_q, regWrite_d;
    logic [REG_ADDR_W-1:0] wbRd_q, wbRd_d;
    logic [XLEN-1:0]       wbData_q, wbData_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic [NUM_REQ-1:0]    reqMasked;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      winner;
    logic                  anyGrant;
    logic [REG_ADDR_W-1:0] winRd;
    logic [XLEN-1:0]       winData;
    logic                  stallInt;
    logic                  setEn;

    // No grants are handed out while reset is held.
    assign reqMasked = bus.req_valid & {NUM_REQ{~reset}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i    (reqMasked),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .valid_o  (anyGrant)
    );

    // Pick out the winning requester's destination and data.
    always_comb begin
        winRd   = '0;
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                winRd   = bus.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                winData = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Next write-port contents and pointer; an x0 transfer still advances the pointer.
    always_comb begin
        regWrite_d = 1'b0;
        wbRd_d     = wbRd_q;
        wbData_d   = wbData_q;
        ptr_d      = ptr_q;
        if (anyGrant) begin
            regWrite_d = (winRd != X0);
            wbRd_d     = winRd;
            wbData_d   = winData;
            ptr_d      = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    // Hazard detection against in-flight writes; x0 never hazards.
    always_comb begin
        stallInt = bus.issue_valid &
                   (((bus.chk_rs1 != X0) & busy_q[bus.chk_rs1]) |
                    ((bus.chk_rs2 != X0) & busy_q[bus.chk_rs2]) |
                    ((bus.issue_rd != X0) & busy_q[bus.issue_rd]));
        setEn    = bus.issue_valid & ~stallInt & (bus.issue_rd != X0);
    end

    // Scoreboard update: clear on retiring write, then set so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (regWrite_q) begin
            busy_d = busy_d & ~regMask(wbRd_q);
        end
        if (setEn) begin
            busy_d = busy_d | regMask(bus.issue_rd);
        end
    end

    // State registers; reset drops any pending write and clears the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            regWrite_q <= 1'b0;
            wbRd_q     <= '0;
            wbData_q   <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regWrite_q <= regWrite_d;
            wbRd_q     <= wbRd_d;
            wbData_q   <= wbData_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.RegWrite  = regWrite_q;
    assign bus.wb_rd     = wbRd_q;
    assign bus.wb_data   = wbData_q;
    assign bus.stall     = stallInt;
    assign bus.busy_vec  = busy_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 32x32 register file. Arbitrates up to NUM_REQ write-back sources (ALU, load unit, multiply/CSR) onto the register file's single write port with round-robin fairness, and maintains a per-register busy scoreboard that stalls decode on RAW/WAW hazards against in-flight writes. It sits between the execute/memory units and the register file write port (RegWrite, rd, Result).

## Interface
- NUM_REQ, 3: number of write-back requesters, legal 2..4
- XLEN, 32: data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a write-back pending
- req_ready  out  NUM_REQ  requester i granted this cycle; transfer = valid & ready
- req_rd  in  5*NUM_REQ  destination register of requester i, slice [5i+4:5i]
- req_data  in  XLEN*NUM_REQ  write data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
- RegWrite  out  1  register-file write enable (registered)
- wb_rd  out  5  register-file write address (registered)
- wb_data  out  XLEN  register-file write data, drives Result (registered)
- issue_valid  in  1  decode wants to issue an instruction writing issue_rd
- issue_rd  in  5  destination of the issuing instruction
- chk_rs1, chk_rs2  in  5 each  source registers of the issuing instruction
- stall  out  1  decode must hold; issue not accepted
- busy_vec  out  32  scoreboard state, bit n = write to xn in flight

## Operation
- Reset (async assert): RegWrite=0, wb_rd=0, wb_data=0, busy_vec=0, RR pointer=0; req_ready=0 while reset is high.
- Arbitration: search requesters starting at pointer, wrapping modulo NUM_REQ; first with req_valid=1 gets req_ready=1 (one-hot, at most one). No valid → req_ready all 0.
- On a transfer from requester g: next cycle RegWrite=(req_rd[g]!=0), wb_rd=req_rd[g], wb_data=req_data[g]; pointer ← (g+1) mod NUM_REQ. No transfer → RegWrite=0, pointer, wb_rd and wb_data hold.
- Transfer with rd=x0 is accepted (consumes the grant, advances pointer) but produces RegWrite=0.
- Write port is always ready; arbiter never back-pressures the winner.
- stall = issue_valid & ((chk_rs1!=0 & busy[chk_rs1]) | (chk_rs2!=0 & busy[chk_rs2]) | (issue_rd!=0 & busy[issue_rd])). Combinational.
- Set: issue_valid & !stall & issue_rd!=0 → busy[issue_rd] ← 1.
- Clear: RegWrite=1 → busy[wb_rd] ← 0 at the same edge the register file captures the write.
- Same register set and cleared in one cycle: set wins (clear suppressed).
- Clear of a non-busy register is a no-op; x0 never becomes busy.

## Timing
- Request accepted at edge E0 (end of cycle 0); RegWrite/wb_* valid cycle 1; register file updated and busy bit cleared at edge E1; value readable and stall released in cycle 2.
- Arbitration and stall are combinational in the same cycle; all state changes on clk rising edge or reset assertion.
- Back-to-back: one write-back per cycle sustained; with k requesters continuously valid each is granted once every k cycles.
- Reset mid-transfer: pending write dropped, all busy bits cleared, output idles next cycle.

## Structure
- Shared package: REG_ADDR_W=5, NUM_REGS=32, XLEN default, x0 constant.
- One sub-module natural: rr_arbiter (NUM_REQ request vector, pointer, one-hot grant, encoded winner); scoreboard and output register stay in the top.

## Test plan
- Reset: hold reset with req_valid=3'b111 → req_ready=0, RegWrite=0, busy_vec=0; release → first grant to requester 0.
- Fairness: all three valid for 6 cycles, rd=1/2/3 → grants 0,1,2,0,1,2; RegWrite each cycle one cycle later with matching wb_rd/wb_data.
- x0 write: requester 1 valid, rd=0, data=32'hDEADBEEF → req_ready[1]=1, RegWrite stays 0, pointer advances to 2.
- RAW stall: issue rd=5, next cycle check rs1=5 → stall=1; requester 0 writes x5 → stall drops two cycles after acceptance, busy_vec[5]=0.
- WAW and x0 checks: busy x7, issue_rd=7 → stall=1; rs1=rs2=issue_rd=0 → stall=0 regardless of busy_vec.
- Async reset mid-operation: assert reset between edges with busy_vec=32'h0000_00A0 and transfer pending → busy_vec=0, RegWrite=0 immediately, no write issued after release.
